// File: rtl/udp_payload_reader.sv
// Streams a UDP payload out of the 32-bit payload RAM as MSB-first bytes.
// Each word costs one FETCH and one WAIT cycle; bytes then hold under byte_ready backpressure.
module udp_payload_reader #(
  parameter int ADDR_W    = 9,
  parameter int BASE_ADDR = 1
) (
  input  logic              e_txc,
  input  logic              reset_n,
  input  logic              start,
  input  logic [15:0]       byte_len,
  output logic [ADDR_W-1:0] ram_rd_addr,
  input  logic [31:0]       ram_rd_data,
  output logic [7:0]        byte_data,
  output logic              byte_valid,
  input  logic              byte_ready,
  output logic              last,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_WAIT, S_SEND} state_t;

  state_t            state_q, state_d;
  logic [15:0]       len_q, len_d;
  logic [15:0]       cnt_q, cnt_d;
  logic [1:0]        lane_q, lane_d;
  logic [23:0]       word_q, word_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        data_q, data_d;
  logic              vld_q, vld_d;
  logic              last_q, last_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [15:0] len_m1;
  logic [1:0]  lane_inc;
  logic        final_byte;

  assign len_m1     = len_q - 16'd1;
  assign lane_inc   = lane_q + 2'd1;
  assign final_byte = (cnt_q == len_m1);

  // The top byte is taken straight from the RAM in WAIT, so only the lower three lanes are kept.
  function automatic logic [7:0] lane_byte(input logic [23:0] w, input logic [1:0] l);
    case (l)
      2'd1:    lane_byte = w[23:16];
      2'd2:    lane_byte = w[15:8];
      default: lane_byte = w[7:0];
    endcase
  endfunction

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    lane_d  = lane_q;
    word_d  = word_q;
    addr_d  = addr_q;
    data_d  = data_q;
    vld_d   = vld_q;
    last_d  = last_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (byte_len != 16'd0) begin
            len_d   = byte_len;
            addr_d  = BASE;
            cnt_d   = 16'd0;
            lane_d  = 2'd0;
            busy_d  = 1'b1;
            state_d = S_FETCH;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      S_FETCH: state_d = S_WAIT;
      S_WAIT: begin
        word_d  = ram_rd_data[23:0];
        data_d  = ram_rd_data[31:24];
        vld_d   = 1'b1;
        last_d  = final_byte;
        state_d = S_SEND;
      end
      S_SEND: begin
        if (vld_q && byte_ready) begin
          cnt_d = cnt_q + 16'd1;
          if (final_byte) begin
            vld_d   = 1'b0;
            last_d  = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else if (lane_q == 2'd3) begin
            vld_d   = 1'b0;
            addr_d  = addr_q + 1'b1;
            lane_d  = 2'd0;
            state_d = S_FETCH;
          end else begin
            lane_d = lane_inc;
            data_d = lane_byte(word_q, lane_inc);
            last_d = (cnt_d == len_m1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge e_txc or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      cnt_q   <= '0;
      lane_q  <= '0;
      word_q  <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      vld_q   <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      lane_q  <= lane_d;
      word_q  <= word_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      vld_q   <= vld_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign ram_rd_addr = addr_q;
  assign byte_data   = data_q;
  assign byte_valid  = vld_q;
  assign last        = last_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule

// File: tb/tb_udp_payload_reader.sv
// Directed bench for udp_payload_reader: one instance at the default base, one at 510 to cover address wrap.
module tb_udp_payload_reader;

  logic e_txc = 1'b0;
  always #5 e_txc = ~e_txc;

  logic        reset_n, start, byte_ready;
  logic [15:0] byte_len;
  logic [8:0]  addr1, addr2;
  logic [31:0] rdata1, rdata2;
  logic [7:0]  data1, data2;
  logic        vld1, vld2, last1, last2, busy1, busy2, done1, done2;
  logic [31:0] mem1 [512];
  logic [31:0] mem2 [512];

  always @(posedge e_txc) begin
    rdata1 <= mem1[addr1];
    rdata2 <= mem2[addr2];
  end

  udp_payload_reader #(.ADDR_W(9), .BASE_ADDR(1)) dut1 (
    .e_txc(e_txc), .reset_n(reset_n), .start(start), .byte_len(byte_len),
    .ram_rd_addr(addr1), .ram_rd_data(rdata1), .byte_data(data1), .byte_valid(vld1),
    .byte_ready(byte_ready), .last(last1), .busy(busy1), .done(done1));

  udp_payload_reader #(.ADDR_W(9), .BASE_ADDR(510)) dut2 (
    .e_txc(e_txc), .reset_n(reset_n), .start(start), .byte_len(byte_len),
    .ram_rd_addr(addr2), .ram_rd_data(rdata2), .byte_data(data2), .byte_valid(vld2),
    .byte_ready(byte_ready), .last(last2), .busy(busy2), .done(done2));

  bit         sel;
  logic [8:0] o_addr;
  logic [7:0] o_data;
  logic       o_vld, o_last, o_busy, o_done;
  assign o_addr = sel ? addr2 : addr1;
  assign o_data = sel ? data2 : data1;
  assign o_vld  = sel ? vld2  : vld1;
  assign o_last = sel ? last2 : last1;
  assign o_busy = sel ? busy2 : busy1;
  assign o_done = sel ? done2 : done1;

  int checks = 0;
  int failures = 0;

  logic [7:0]  got [$];
  logic [8:0]  addrs [$];
  logic [7:0]  exp_b [20];
  logic [31:0] words [5];
  int          done_cyc, first_vld, last_cnt, last_idx, stall_bad;
  logic        done_vld, done_busy, busy0;
  logic [8:0]  addr0, addr_pre;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_addr"}, 32'(o_addr), 32'd0);
    chk({tag, "_data"}, 32'(o_data), 32'd0);
    chk({tag, "_vld"},  32'(o_vld),  32'd0);
    chk({tag, "_last"}, 32'(o_last), 32'd0);
    chk({tag, "_busy"}, 32'(o_busy), 32'd0);
    chk({tag, "_done"}, 32'(o_done), 32'd0);
  endtask

  // cyc counts edges after the start edge; bytes handshake at the edge following their sample.
  task automatic run_frame(input logic [15:0] len, input bit rnd, input int mid_at, input int abort_at);
    bit         pstall = 1'b0;
    logic [7:0] pdata = 8'd0;
    logic       plast = 1'b0;
    got.delete();
    addrs.delete();
    done_cyc = -1; first_vld = -1; last_cnt = 0; last_idx = -1; stall_bad = 0;
    done_vld = 1'bx; done_busy = 1'bx;
    start = 1'b1;
    byte_len = len;
    @(posedge e_txc); #1;
    start = 1'b0;
    busy0 = o_busy;
    addr0 = o_addr;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (cyc > 0) begin
        @(posedge e_txc); #1;
      end
      if (abort_at > 0 && got.size() >= abort_at) break;
      if (o_busy && (addrs.size() == 0 || addrs[$] !== o_addr)) addrs.push_back(o_addr);
      if (o_done) begin
        done_cyc = cyc; done_vld = o_vld; done_busy = o_busy;
        break;
      end
      if (pstall && (o_data !== pdata || o_last !== plast)) stall_bad++;
      if (o_vld && first_vld < 0) first_vld = cyc;
      start = (cyc == mid_at);
      if (cyc == mid_at) byte_len = 16'd4;
      byte_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (o_vld && byte_ready) begin
        got.push_back(o_data);
        if (o_last) begin
          last_cnt++;
          last_idx = got.size() - 1;
        end
      end
      pstall = o_vld && !byte_ready;
      pdata = o_data;
      plast = o_last;
    end
    start = 1'b0;
  endtask

  task automatic check_frame(input string tag, input int n, input logic [8:0] a0);
    int nw = (n + 3) / 4;
    chk({tag, "_nbytes"}, 32'(got.size()), 32'(n));
    for (int i = 0; i < got.size() && i < n; i++)
      chk($sformatf("%s_byte%0d", tag, i), 32'(got[i]), 32'(exp_b[i]));
    chk({tag, "_last_cnt"}, 32'(last_cnt), (n > 0) ? 32'd1 : 32'd0);
    if (n > 0) chk({tag, "_last_idx"}, 32'(last_idx), 32'(n - 1));
    chk({tag, "_naddr"}, 32'(addrs.size()), 32'(nw));
    for (int k = 0; k < addrs.size() && k < nw; k++)
      chk($sformatf("%s_addr%0d", tag, k), 32'(addrs[k]), 32'(9'(a0 + 9'(k))));
    chk({tag, "_done_seen"}, 32'(done_cyc >= 0), 32'd1);
    chk({tag, "_done_vld"},  32'(done_vld),  32'd0);
    chk({tag, "_done_busy"}, 32'(done_busy), 32'd0);
    @(posedge e_txc); #1;
    chk({tag, "_done_clr"}, 32'(o_done), 32'd0);
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; byte_len = 16'd0; byte_ready = 1'b0; sel = 1'b0;
    words[0] = 32'h48454C4C; words[1] = 32'h4F20414C; words[2] = 32'h494E5820;
    words[3] = 32'h41583731; words[4] = 32'h30310A0D;
    for (int a = 0; a < 512; a++) begin
      mem1[a] = 32'hDEADBEEF;
      mem2[a] = 32'hDEADBEEF;
    end
    for (int k = 0; k < 5; k++) begin
      mem1[k + 1] = words[k];
      for (int j = 0; j < 4; j++) exp_b[4 * k + j] = 8'(words[k] >> (24 - 8 * j));
    end
    mem2[510] = words[0]; mem2[511] = words[1]; mem2[0] = words[2];

    #12;
    chk_zero("reset");
    reset_n = 1'b1;
    @(posedge e_txc); #1;

    // Full 20-byte frame, sink always ready: check exact timing too.
    run_frame(16'd20, 1'b0, -1, 0);
    chk("f20_busy0", 32'(busy0), 32'd1);
    chk("f20_addr0", 32'(addr0), 32'd1);
    chk("f20_first_vld", 32'(first_vld), 32'd2);
    chk("f20_done_cyc", 32'(done_cyc), 32'd30);
    check_frame("f20", 20, 9'd1);

    run_frame(16'd6, 1'b0, -1, 0);
    chk("f6_done_cyc", 32'(done_cyc), 32'd10);
    check_frame("f6", 6, 9'd1);

    run_frame(16'd20, 1'b1, -1, 0);
    chk("rnd_stall_stable", 32'(stall_bad), 32'd0);
    check_frame("rnd", 20, 9'd1);

    addr_pre = o_addr;
    run_frame(16'd0, 1'b0, -1, 0);
    chk("z_done_cyc", 32'(done_cyc), 32'd0);
    chk("z_busy0", 32'(busy0), 32'd0);
    chk("z_no_vld", 32'(first_vld), 32'hFFFFFFFF);
    chk("z_addr_hold", 32'(addr0), 32'(addr_pre));
    check_frame("z", 0, 9'd1);
    chk("z_addr_after", 32'(o_addr), 32'(addr_pre));

    run_frame(16'd20, 1'b0, 10, 0);
    check_frame("midstart", 20, 9'd1);

    run_frame(16'd20, 1'b0, -1, 7);
    chk("abort_nbytes", 32'(got.size()), 32'd7);
    chk("abort_no_done", 32'(done_cyc), 32'hFFFFFFFF);
    chk("abort_busy_pre", 32'(o_busy), 32'd1);
    #1 reset_n = 1'b0;
    #1 chk_zero("abort_rst");
    #3 reset_n = 1'b1;
    @(posedge e_txc); #1;
    chk("abort_post_done", 32'(o_done), 32'd0);

    run_frame(16'd4, 1'b0, -1, 0);
    check_frame("f4", 4, 9'd1);

    sel = 1'b1;
    run_frame(16'd12, 1'b0, -1, 0);
    chk("wrap_addr0", 32'(addr0), 32'd510);
    check_frame("wrap", 12, 9'd510);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
